// File: rtl/dice_pkg.sv
// Shared types and widths for the dice roll stabilizer.
package dice_pkg;

    localparam int ROLL_W = 8;   // width of the accepted-roll counter
    localparam int CNT_W  = 4;   // width of the frame counters

    typedef logic [1:0] dice_val_t;

    localparam dice_val_t NO_DICE = 2'd0;

    typedef enum logic [1:0] {
        ST_WAIT_CLEAR = 2'd0,
        ST_WAIT_DICE  = 2'd1,
        ST_STABILIZE  = 2'd2,
        ST_PRESENT    = 2'd3
    } dice_state_e;

endpackage

// File: rtl/dice_frame_counter.sv
// Saturating frame counter. hit_o looks one increment ahead: it is high
// when the next increment would reach (or has already reached) the limit,
// so the controller can act on the same frame that completes the count
// without any combinational path from clr_i/inc_i back to hit_o.
// clr_i and inc_i together restart the count at 1.
module dice_frame_counter
    import dice_pkg::*;
(
    input  logic             clk,
    input  logic             reset_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] base;

    // Next count: optional clear, then a saturating increment.
    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        cnt_d = base;
        if (inc_i && (base < limit_i)) begin
            cnt_d = base + 1'b1;
        end
    end

    assign hit_o = ({1'b0, cnt_q} + 1'b1) >= {1'b0, limit_i};

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dice_roll_stabilizer.sv
// Accepts a dice roll only after it has been seen unchanged for a number
// of camera frames, offers it to the game with a valid/ready handshake and
// re-arms only after the table has been seen empty for a number of frames.
module dice_roll_stabilizer
    import dice_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned CLEAR_FRAMES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_done,
    input  logic              class_valid,
    input  logic [1:0]        class_value,
    input  logic              game_ready,
    output logic              dice_valid,
    output logic [1:0]        dice_value,
    output logic              armed,
    output logic [ROLL_W-1:0] roll_count
);

    localparam logic [CNT_W-1:0] STB_LIMIT = CNT_W'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0] CLR_LIMIT = CNT_W'(CLEAR_FRAMES);
    localparam bit               STB_ONE   = (STABLE_FRAMES == 1);

    dice_state_e       state_q, state_d;
    dice_val_t         cand_q, cand_d;
    logic [ROLL_W-1:0] roll_q, roll_d;
    logic              valid_q, valid_d;
    dice_val_t         value_q, value_d;

    dice_val_t         sample;
    logic              clr_inc, clr_clr, clr_hit;
    logic              stb_inc, stb_clr, stb_hit;

    // An invalid classification is treated exactly like an empty table.
    assign sample = class_valid ? class_value : NO_DICE;

    dice_frame_counter u_clr_cnt (
        .clk      (clk),
        .reset_ni (reset),
        .inc_i    (clr_inc),
        .clr_i    (clr_clr),
        .limit_i  (CLR_LIMIT),
        .hit_o    (clr_hit)
    );

    dice_frame_counter u_stb_cnt (
        .clk      (clk),
        .reset_ni (reset),
        .inc_i    (stb_inc),
        .clr_i    (stb_clr),
        .limit_i  (STB_LIMIT),
        .hit_o    (stb_hit)
    );

    // FSM next state: frames advance the state, game_ready only ends PRESENT.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        roll_d  = roll_q;
        clr_inc = 1'b0;
        clr_clr = 1'b0;
        stb_inc = 1'b0;
        stb_clr = 1'b0;
        case (state_q)
            ST_WAIT_CLEAR: begin
                if (frame_done) begin
                    if (sample == NO_DICE) begin
                        if (clr_hit) begin
                            state_d = ST_WAIT_DICE;
                            clr_clr = 1'b1;
                        end else begin
                            clr_inc = 1'b1;
                        end
                    end else begin
                        clr_clr = 1'b1;
                    end
                end
            end
            ST_WAIT_DICE: begin
                if (frame_done && (sample != NO_DICE)) begin
                    cand_d  = sample;
                    stb_clr = 1'b1;
                    stb_inc = 1'b1;
                    state_d = STB_ONE ? ST_PRESENT : ST_STABILIZE;
                end
            end
            ST_STABILIZE: begin
                if (frame_done) begin
                    if (sample == NO_DICE) begin
                        stb_clr = 1'b1;
                        state_d = ST_WAIT_DICE;
                    end else if (sample == cand_q) begin
                        stb_inc = 1'b1;
                        if (stb_hit) begin
                            state_d = ST_PRESENT;
                        end
                    end else begin
                        cand_d  = sample;
                        stb_clr = 1'b1;
                        stb_inc = 1'b1;
                    end
                end
            end
            ST_PRESENT: begin
                // Frames seen here are deliberately ignored.
                if (game_ready) begin
                    state_d = ST_WAIT_CLEAR;
                    roll_d  = roll_q + 1'b1;
                    clr_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_CLEAR;
            end
        endcase
        valid_d = (state_d == ST_PRESENT);
        value_d = valid_d ? cand_d : NO_DICE;
    end

    // State, candidate, roll counter and registered offer outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_WAIT_CLEAR;
            cand_q  <= NO_DICE;
            roll_q  <= '0;
            valid_q <= 1'b0;
            value_q <= NO_DICE;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            roll_q  <= roll_d;
            valid_q <= valid_d;
            value_q <= value_d;
        end
    end

    assign dice_valid = valid_q;
    assign dice_value = value_q;
    assign armed      = (state_q == ST_WAIT_DICE) || (state_q == ST_STABILIZE);
    assign roll_count = roll_q;

endmodule

// File: doc/dice_roll_stabilizer.md
DICE_ROLL_STABILIZER -- requirements
Module: dice_roll_stabilizer

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 4: consecutive identical non-zero frames needed to accept a roll, legal 1..15.
REQ-002 SHALL have parameter CLEAR_FRAMES, default 2: consecutive no-dice frames needed to re-arm, legal 1..15.
REQ-003 SHALL have port clk  in  1  system clock; single clock domain.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset (reset==0 resets on the clk rising edge).
REQ-005 SHALL have port frame_done  in  1  one-cycle pulse at the end of each camera frame.
REQ-006 SHALL have port class_valid  in  1  detector classification valid; sampled only when frame_done==1.
REQ-007 SHALL have port class_value  in  2  detector result: 0 means no dice or unknown, 1..3 is the dice value.
REQ-008 SHALL have port game_ready  in  1  the downstream game logic accepts a roll.
REQ-009 SHALL have port dice_valid  out  1  a stable roll is offered.
REQ-010 SHALL have port dice_value  out  2  the offered roll, 1..3.
REQ-011 SHALL have port armed  out  1  high in WAIT_DICE and STABILIZE.
REQ-012 SHALL have port roll_count  out  8  count of accepted rolls.

Function
REQ-013 SHALL form a frame sample only on cycles with frame_done==1: sample = class_valid ? class_value : 0; all other cycles SHALL leave state and counters unchanged, except the handshake in REQ-018.
REQ-014 SHALL implement four states: WAIT_CLEAR, WAIT_DICE, STABILIZE, PRESENT.
REQ-015 In WAIT_CLEAR: a zero sample increments clr_cnt; a non-zero sample clears clr_cnt. When clr_cnt reaches CLEAR_FRAMES, the FSM SHALL go to WAIT_DICE and clear clr_cnt.
REQ-016 In WAIT_DICE: a non-zero sample loads cand=sample and stb_cnt=1, then goes to STABILIZE, or directly to PRESENT when STABLE_FRAMES==1. A zero sample stays in WAIT_DICE.
REQ-017 In STABILIZE, on each sample:
 - sample==cand: increment stb_cnt; reaching STABLE_FRAMES goes to PRESENT.
 - sample non-zero and different from cand: reload cand and set stb_cnt=1.
 - sample zero: go to WAIT_DICE.
REQ-018 In PRESENT: dice_valid=1 and dice_value=cand, both held constant until a cycle with game_ready==1. That cycle completes the handshake: go to WAIT_CLEAR, increment roll_count, and clear clr_cnt.
REQ-019 dice_valid SHALL be registered; it rises on the cycle after the frame_done edge that completes the STABLE_FRAMES-th matching sample.
REQ-020 Frame samples arriving in PRESENT SHALL be ignored, including one in the same cycle as the handshake; that frame does not count toward CLEAR_FRAMES.
REQ-021 game_ready outside PRESENT SHALL have no effect.
REQ-022 dice_valid SHALL be 0 and dice_value SHALL be 0 in all states other than PRESENT.
REQ-023 roll_count SHALL wrap from 255 to 0.
REQ-024 clr_cnt and stb_cnt SHALL each be 4 bits and never exceed their threshold.

Reset
REQ-025 While reset==0, on the clk edge the block SHALL enter WAIT_CLEAR and clear clr_cnt, stb_cnt, cand and roll_count. Outputs SHALL then be dice_valid=0, dice_value=0, armed=0, roll_count=0.
REQ-026 Reset SHALL abort any state, including PRESENT, with no handshake completed; a dice already present after reset SHALL NOT be reported until it has been cleared.

Structure
REQ-027 A shared package dice_pkg SHALL hold:
 - the state enum;
 - typedef dice_val_t (2 bits);
 - constant NO_DICE = 2'd0;
 - the widths of roll_count and the frame counters.
REQ-028 The two frame counters SHALL use one reused sub-module, dice_frame_counter: a saturating 4-bit counter with inc, clr and limit inputs and a hit output.

Verification
REQ-029 Scenario 1, acceptance: after reset release, drive 2 zero frames, then 4 frames of value 3 -> armed=1 after the 2nd zero frame; dice_valid=1 and dice_value=3 one cycle after the 4th frame; stays asserted until game_ready=1; then roll_count=1.
REQ-030 Scenario 2, value change: frames 2,2,1,1,1,1 -> exactly one offer, with dice_value=1, after the 6th frame.
REQ-031 Scenario 3, no re-arm without clearing: after an accepted roll, keep value 3 for 10 frames -> no dice_valid; then 2 zero frames and 4 frames of value 2 -> offer with dice_value=2.
REQ-032 Scenario 4, dropouts and boundaries:
 - frames 1,1,1,0 -> no offer, back to WAIT_DICE;
 - class_valid=0 during a frame counts as zero;
 - frame_done in the same cycle as game_ready in PRESENT -> that frame is not counted toward clearing.
REQ-033 Scenario 5, reset mid-offer: reset=0 for 1 cycle while in PRESENT -> dice_valid=0 the next cycle, roll_count=0, and the held dice is not re-offered until 2 zero frames have passed.
REQ-034 Scenario 6, wrap-around: 256 accepted rolls -> roll_count returns to 0.
